// File: rtl/issue_ctrl.sv
// In-order fetch/issue controller: RAW interlock, BNEQ hold/redirect, HALT drain, stall counter.
// Optional ISSUE_CTRL_INTERLOCK_EN enables the scoreboard-based RAW hazard check.
module issue_ctrl #(
  parameter logic [15:0] START_ADDR = 16'd0,
  parameter int unsigned WB_LAT     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] prom_addr,
  input  logic [26:0] prom_data,
  input  logic        br_valid,
  input  logic        br_taken,
  output logic [26:0] instr_out,
  output logic        instr_valid,
  output logic        busy,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_BR_WAIT, S_DRAIN, S_HALTED
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] bpc;
  logic [15:0] off;
  logic [15:0] stall_inc;
  logic        imm_f;
  logic [3:0]  opc;
  logic        is_halt;
  logic        is_bneq;
  logic        hazard;
  logic        drain_done;

  assign prom_addr = pc;
  assign imm_f     = prom_data[26];
  assign opc       = prom_data[25:22];
  assign is_halt   = imm_f && (opc == 4'd0);
  assign is_bneq   = (opc == 4'd13);
  assign stall_inc = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;

`ifdef ISSUE_CTRL_INTERLOCK_EN
  logic [WB_LAT-1:0] sb_valid;
  logic [WB_LAT-1:0] sb_shl;
  logic [2:0]        sb_rd [WB_LAT];
  logic [2:0]        rd;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic              is_wr;
  logic              use_rs2;
  logic              sb_in;

  assign rd      = prom_data[21:19];
  assign rs1     = prom_data[18:16];
  assign rs2     = prom_data[2:0];
  assign is_wr   = (opc >= 4'd1) && (opc <= 4'd12);
  assign use_rs2 = is_wr && !imm_f;
  assign sb_in   = (state == S_RUN) && !hazard && is_wr;

  // Drain may finish once the entries surviving the next shift are all empty
  assign sb_shl     = sb_valid << 1;
  assign drain_done = (sb_shl == '0);

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < WB_LAT; i++) begin
      if (sb_valid[i]) begin
        if ((is_wr || is_bneq) && (sb_rd[i] == rs1)) hazard = 1'b1;
        if (use_rs2 && (sb_rd[i] == rs2))           hazard = 1'b1;
        if (is_bneq && (sb_rd[i] == rd))            hazard = 1'b1;
      end
    end
  end

  // Scoreboard: slot 0 holds the writer issued at the previous edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid <= '0;
      for (int unsigned i = 0; i < WB_LAT; i++) sb_rd[i] <= 3'd0;
    end else begin
      sb_valid <= {sb_valid[WB_LAT-1:0], sb_in} >> 0 == '0 ? WB_LAT'(sb_in) : WB_LAT'({sb_valid, sb_in});
      sb_rd[0] <= rd;
      for (int unsigned i = 1; i < WB_LAT; i++) sb_rd[i] <= sb_rd[i-1];
    end
  end
`else
  logic [2:0] drain_cnt;

  assign hazard     = 1'b0;
  assign drain_done = (drain_cnt == 3'd0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= START_ADDR;
      bpc         <= 16'd0;
      off         <= 16'd0;
      instr_out   <= 27'd0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      stall_cnt   <= 16'd0;
`ifndef ISSUE_CTRL_INTERLOCK_EN
      drain_cnt   <= 3'd0;
`endif
    end else begin
      instr_out   <= 27'd0;
      instr_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc        <= START_ADDR;
            stall_cnt <= 16'd0;
            state     <= S_RUN;
            busy      <= 1'b1;
            halted    <= 1'b0;
          end
        end
        S_RUN: begin
          if (hazard) begin
            stall_cnt <= stall_inc;
          end else if (is_halt) begin
            state <= S_DRAIN;
`ifndef ISSUE_CTRL_INTERLOCK_EN
            drain_cnt <= 3'(WB_LAT - 1);
`endif
          end else begin
            instr_out   <= prom_data;
            instr_valid <= 1'b1;
            pc          <= pc + 16'd1;
            if (is_bneq) begin
              bpc   <= pc;
              off   <= prom_data[15:0];
              state <= S_BR_WAIT;
            end
          end
        end
        S_BR_WAIT: begin
          stall_cnt <= stall_inc;
          if (br_valid) begin
            pc    <= br_taken ? bpc + off : bpc + 16'd1;
            state <= S_RUN;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end
`ifndef ISSUE_CTRL_INTERLOCK_EN
          else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
`endif
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
